// File: rtl/pool_window_feeder_if.sv
// Bundles the sample stream, threshold stream and compare-block outputs of the window feeder.
// Latency: none, wiring only.
// Backpressure: s_ready/th_ready from the feeder; the compare side cannot stall.
interface pool_window_feeder_if #(
    parameter int LANES = 7,
    parameter int DW    = 8,
    parameter int THW   = 24
);
    logic                  s_valid;
    logic [DW-1:0]         s_data;
    logic                  s_ready;
    logic                  th_valid;
    logic [THW-1:0]        th_data;
    logic                  th_ready;
    logic [LANES*DW-1:0]   out_Data;
    logic                  out_valid;
    logic [THW-1:0]        threhold;
    logic                  loadthrehold;
    logic                  bin_valid;
    logic                  ch_done;

    // Feeder side: consumes both streams and drives the compare block.
    modport master (
        input  s_valid, s_data, th_valid, th_data,
        output s_ready, th_ready, out_Data, out_valid,
               threhold, loadthrehold, bin_valid, ch_done
    );

    // Environment side: produces the streams and observes the compare-block signals.
    modport slave (
        output s_valid, s_data, th_valid, th_data,
        input  s_ready, th_ready, out_Data, out_valid,
               threhold, loadthrehold, bin_valid, ch_done
    );
endinterface

// File: rtl/pool_window_feeder.sv
// Packs LANES signed samples into one window and loads a threshold word before each channel.
// Latency: out_valid 1 cycle after the last lane is accepted; bin_valid 2 cycles after out_valid.
// Backpressure: s_ready only in FILL, th_ready only in TH_WAIT; the compare side is fire-and-forget.
module pool_window_feeder #(
    parameter int LANES  = 7,
    parameter int DW     = 8,
    parameter int THW    = 24,
    parameter int CH_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    pool_window_feeder_if.master    fd
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WIN_W  = 16;

    typedef enum logic [1:0] {
        TH_WAIT  = 2'd0,
        TH_PULSE = 2'd1,
        FILL     = 2'd2
    } state_t;

    state_t                 state;
    logic                   s_ready_q;
    logic                   th_ready_q;
    logic [THW-1:0]         threhold_q;
    logic                   load_q;

    logic [LANE_W-1:0]      lane_cnt;
    logic [WIN_W-1:0]       win_cnt;
    logic [DW-1:0]          shadow [LANES-1];
    logic [LANES*DW-1:0]    out_q;
    logic                   out_valid_q;
    logic                   ch_done_q;
    logic                   bv_stage;
    logic                   bin_valid_q;

    logic                   s_hs;
    logic                   th_hs;
    logic                   last_lane;
    logic                   last_win;

    assign s_hs      = fd.s_valid & s_ready_q;
    assign th_hs     = fd.th_valid & th_ready_q;
    assign last_lane = (lane_cnt == LANE_W'(LANES - 1));
    assign last_win  = (win_cnt == WIN_W'(CH_LEN - 1));

    // Channel sequencing: wait for a threshold, strobe the load, then stream windows until the channel ends.
    // The strobe is registered off TH_PULSE so threhold has been stable a full cycle before it rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= TH_WAIT;
            th_ready_q <= 1'b1;
            s_ready_q  <= 1'b0;
            threhold_q <= '0;
            load_q     <= 1'b0;
        end else begin
            load_q <= (state == TH_PULSE);
            case (state)
                TH_WAIT: begin
                    if (th_hs) begin
                        threhold_q <= fd.th_data;
                        th_ready_q <= 1'b0;
                        state      <= TH_PULSE;
                    end
                end
                TH_PULSE: begin
                    s_ready_q <= 1'b1;
                    state     <= FILL;
                end
                FILL: begin
                    if (s_hs && last_lane && last_win) begin
                        s_ready_q  <= 1'b0;
                        th_ready_q <= 1'b1;
                        state      <= TH_WAIT;
                    end
                end
                default: begin
                    s_ready_q  <= 1'b0;
                    th_ready_q <= 1'b1;
                    state      <= TH_WAIT;
                end
            endcase
        end
    end

    // Window assembly: collect lanes in a shadow register and publish the whole window in one cycle,
    // so out_Data only ever changes on the out_valid cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt    <= '0;
            win_cnt     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ch_done_q   <= 1'b0;
            for (int i = 0; i < LANES - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            ch_done_q   <= 1'b0;
            if (s_hs) begin
                for (int i = 0; i < LANES - 1; i++) begin
                    if (lane_cnt == LANE_W'(i)) begin
                        shadow[i] <= fd.s_data;
                    end
                end
                if (last_lane) begin
                    for (int i = 0; i < LANES - 1; i++) begin
                        out_q[(LANES-1-i)*DW +: DW] <= shadow[i];
                    end
                    out_q[DW-1:0] <= fd.s_data;
                    out_valid_q   <= 1'b1;
                    lane_cnt      <= '0;
                    if (last_win) begin
                        win_cnt   <= '0;
                        ch_done_q <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end else begin
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end
        end
    end

    // Binary-result valid: out_valid delayed through the compare block's max and binary registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bv_stage    <= 1'b0;
            bin_valid_q <= 1'b0;
        end else begin
            bv_stage    <= out_valid_q;
            bin_valid_q <= bv_stage;
        end
    end

    assign fd.s_ready      = s_ready_q;
    assign fd.th_ready     = th_ready_q;
    assign fd.out_Data     = out_q;
    assign fd.out_valid    = out_valid_q;
    assign fd.threhold     = threhold_q;
    assign fd.loadthrehold = load_q;
    assign fd.bin_valid    = bin_valid_q;
    assign fd.ch_done      = ch_done_q;
endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: scenario tasks against a transaction-level reference model.
// Latency: model schedules out_valid/bin_valid/loadthrehold by cycle number.
// Backpressure: model decides its own expected ready and uses it for handshakes.
module tb_pool_window_feeder;
    localparam int LANES  = 7;
    localparam int DW     = 8;
    localparam int THW    = 24;
    localparam int CH_LEN = 2;
    localparam int WW     = LANES * DW;
    localparam int VW     = 6 + WW + THW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pool_window_feeder_if #(.LANES(LANES), .DW(DW), .THW(THW)) bus ();

    pool_window_feeder #(.LANES(LANES), .DW(DW), .THW(THW), .CH_LEN(CH_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .fd  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int             cyc = 0;
    int             fill_from = 0;
    int             wins = 0;
    bit             need_th = 1'b1;
    logic [DW-1:0]  lanes[$];
    logic [WW-1:0]  m_data = '0;
    logic [THW-1:0] m_thr = '0;
    bit             m_ov = 1'b0;
    bit             m_cd = 1'b0;
    bit             ld_at[int];
    bit             bv_at[int];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit m_s_rdy();
        return !need_th && (cyc >= fill_from);
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.s_ready, bus.th_ready, bus.out_valid, bus.loadthrehold,
                bus.bin_valid, bus.ch_done, bus.out_Data, bus.threhold};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic ld;
        logic bv;
        ld = (ld_at.exists(cyc) != 0);
        bv = (bv_at.exists(cyc) != 0);
        return {m_s_rdy(), need_th, m_ov, ld, bv, m_cd, m_data, m_thr};
    endfunction

    // Drive one cycle of inputs, advance to the next clock edge and update the model.
    task automatic step(input bit sv, input logic [DW-1:0] sd, input bit tv, input logic [THW-1:0] td);
        bit hs_s;
        bit hs_t;
        bus.s_valid  = sv;
        bus.s_data   = sd;
        bus.th_valid = tv;
        bus.th_data  = td;
        hs_s = sv && m_s_rdy();
        hs_t = tv && need_th;
        @(posedge clk);
        cyc++;
        m_ov = 1'b0;
        m_cd = 1'b0;
        if (hs_t) begin
            m_thr          = td;
            need_th        = 1'b0;
            fill_from      = cyc + 1;
            ld_at[cyc + 1] = 1'b1;
        end
        if (hs_s) begin
            lanes.push_back(sd);
            if (lanes.size() == LANES) begin
                m_data = '0;
                foreach (lanes[i]) m_data = {m_data[WW-DW-1:0], lanes[i]};
                lanes.delete();
                m_ov = 1'b1;
                bv_at[cyc + 2] = 1'b1;
                wins++;
                if (wins == CH_LEN) begin
                    m_cd    = 1'b1;
                    wins    = 0;
                    need_th = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.th_valid = 1'b0;
        bus.th_data  = '0;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1 rst = 1'b0;
        need_th   = 1'b1;
        fill_from = 0;
        wins      = 0;
        lanes.delete();
        m_data = '0;
        m_thr  = '0;
        m_ov   = 1'b0;
        m_cd   = 1'b0;
        ld_at.delete();
        bv_at.delete();
    endtask

    // Threshold handshake followed by the pulse cycle; leaves the feeder in its first FILL cycle.
    task automatic load_th(input logic [THW-1:0] td);
        step(1'b0, '0, 1'b1, td);
        step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        logic [VW-1:0] rst_vec;
        rst_vec = '0;
        rst_vec[VW-2] = 1'b1;
        rst = 1'b1;
        bus.s_valid  = 1'b1;
        bus.s_data   = 8'h5A;
        bus.th_valid = 1'b1;
        bus.th_data  = 24'hABCDEF;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        n_cmp++;
        if (dut_vec() !== rst_vec) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", dut_vec(), rst_vec);
        end
        do_reset();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_threshold_load();
        logic [THW+2:0] want [3];
        logic [THW+2:0] got;
        want[0] = {1'b0, 1'b0, 1'b0, 24'h80001A};
        want[1] = {1'b1, 1'b0, 1'b1, 24'h80001A};
        want[2] = {1'b1, 1'b0, 1'b0, 24'h80001A};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) step(1'b0, '0, 1'b1, 24'h80001A);
            else        step(1'b0, '0, 1'b0, 24'h123456);
            got = {bus.s_ready, bus.th_ready, bus.loadthrehold, bus.threhold};
            n_cmp++;
            if (got !== want[k]) begin
                n_bad++;
                $display("FAIL th_load cycle %0d: got %h want %h", k, got, want[k]);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL th_load_model cycle %0d: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        load_th(24'($urandom));
        for (int k = 1; k <= 10; k++) begin
            step(k <= 7, 8'(k), 1'b0, '0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stream cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
            if (k == 7) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_Data} !== {1'b1, 56'h01020304050607}) begin
                    n_bad++;
                    $display("FAIL stream_window: got %b %h want 1 01020304050607", bus.out_valid, bus.out_Data);
                end
            end
            if (k == 9) begin
                n_cmp++;
                if (bus.bin_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_bin_valid: got %b want 1", bus.bin_valid);
                end
            end
        end
    endtask

    task automatic test_toggle_valid();
        logic [DW-1:0] smp [7];
        int idx;
        int ov_cnt;
        bit sv;
        smp = '{8'hFF, 8'h80, 8'h7F, 8'h00, 8'h05, 8'hFB, 8'h03};
        idx = 0;
        ov_cnt = 0;
        do_reset();
        load_th(24'($urandom));
        for (int c = 0; c < 17; c++) begin
            sv = (c % 2 == 0) && (idx < 7);
            step(sv, sv ? smp[idx] : 8'($urandom), 1'b0, '0);
            if (sv) idx++;
            if (bus.out_valid === 1'b1) ov_cnt++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL toggle cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({ov_cnt, bus.out_Data} !== {32'd1, 56'hFF807F0005FB03}) begin
            n_bad++;
            $display("FAIL toggle_window: got pulses %0d data %h want 1 FF807F0005FB03", ov_cnt, bus.out_Data);
        end
    endtask

    task automatic test_back_to_back();
        logic [THW-1:0] t0;
        int ov_cnt;
        int cd_cnt;
        int cd_alone;
        t0 = 24'($urandom);
        ov_cnt = 0;
        cd_cnt = 0;
        cd_alone = 0;
        do_reset();
        load_th(t0);
        for (int c = 0; c < 14; c++) begin
            step(1'b1, 8'($urandom), 1'b1, ~t0);
            if (bus.out_valid === 1'b1) ov_cnt++;
            if (bus.ch_done === 1'b1) cd_cnt++;
            if (bus.ch_done === 1'b1 && bus.out_valid !== 1'b1) cd_alone++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({ov_cnt, cd_cnt, cd_alone} !== {32'd2, 32'd1, 32'd0}) begin
            n_bad++;
            $display("FAIL b2b_counts: got ov %0d cd %0d cd_alone %0d want 2 1 0", ov_cnt, cd_cnt, cd_alone);
        end
        n_cmp++;
        if ({bus.s_ready, bus.th_ready, bus.threhold} !== {1'b0, 1'b1, t0}) begin
            n_bad++;
            $display("FAIL b2b_end: got s_rdy %b th_rdy %b thr %h want 0 1 %h",
                     bus.s_ready, bus.th_ready, bus.threhold, t0);
        end
    endtask

    task automatic test_reset_mid_window();
        logic [VW-1:0] rst_vec;
        rst_vec = '0;
        rst_vec[VW-2] = 1'b1;
        do_reset();
        load_th(24'($urandom));
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 8'($urandom), 1'b0, '0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL midrst_pre cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec() !== rst_vec) begin
            n_bad++;
            $display("FAIL midrst_async: got %h want %h", dut_vec(), rst_vec);
        end
        do_reset();
        load_th(24'($urandom));
        for (int k = 9; k <= 15; k++) begin
            step(1'b1, 8'(k), 1'b0, '0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL midrst_post cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({bus.out_valid, bus.ch_done, bus.out_Data} !== {1'b1, 1'b0, 56'h090A0B0C0D0E0F}) begin
            n_bad++;
            $display("FAIL midrst_window: got ov %b cd %b data %h want 1 0 090A0B0C0D0E0F",
                     bus.out_valid, bus.ch_done, bus.out_Data);
        end
    endtask

    task automatic test_th_wait_idle();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 8'($urandom), 1'b0, '0);
            n_cmp++;
            if ({bus.s_ready, bus.out_valid, bus.bin_valid} !== 3'b000) begin
                n_bad++;
                $display("FAIL idle cyc %0d: got s_rdy %b ov %b bv %b want 0 0 0",
                         cyc, bus.s_ready, bus.out_valid, bus.bin_valid);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL idle_model cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int dut_ov;
        int mdl_ov;
        dut_ov = 0;
        mdl_ov = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1, 24'($urandom));
            if (bus.out_valid === 1'b1) dut_ov++;
            if (m_ov) mdl_ov++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dut_ov !== mdl_ov) begin
            n_bad++;
            $display("FAIL random_windows: got %0d want %0d", dut_ov, mdl_ov);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.th_valid = 1'b0;
        bus.th_data  = '0;
        test_reset();
        test_threshold_load();
        test_stream();
        test_toggle_valid();
        test_back_to_back();
        test_reset_mid_window();
        test_th_wait_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
